hilo_mdu_ctrl: RTL

Multiply/divide sequencer and owner of the architectural HI/LO registers. It sits in the E stage beside the ALU.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the decoded funct field.
- Runs a pipelined multiplier or an iterative radix-2 divider.
- Raises a stall toward the hazard unit until the result is ready.
- Commits HI/LO when the instruction leaves E.
- Cancels cleanly on an exception flush.

---
 rtl/hilo_mdu_ctrl_pkg.sv | 33 +++
 rtl/div_radix2_core.sv | 71 +++++++
 rtl/hilo_mdu_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the sequencer state encoding, default latencies, the decided divide-by-zero
// result and the R-type funct codes the block decodes.
package hilo_mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMulWait,
    StDivRun,
    StDivFix,
    StDone
  } mdu_state_e;

  localparam int unsigned MulLatDefault  = 2;
  localparam int unsigned DivIterDefault = 32;

  // Divide by zero does not trap: HI gets the dividend, LO gets all ones.
  localparam logic [31:0] DivZeroLo = 32'hFFFF_FFFF;

  // R-type funct field encodings handled here.
  localparam logic [5:0] FunctMthi  = 6'b010001;
  localparam logic [5:0] FunctMtlo  = 6'b010011;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  // Magnitude of a 32-bit operand; unsigned operands pass through.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load dividend/divisor and begin DIV_ITER steps
//   abort           drop any operation in flight
//   dividend        32-bit magnitude dividend
//   divisor         32-bit magnitude divisor (non-zero)
//   last            high during the cycle whose edge performs the final step
//   quot, rem       magnitude quotient and remainder, valid after the final step
module div_radix2_core
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_ITER = DivIterDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int unsigned CntW = $clog2(DIV_ITER);

  logic [63:0]     rq_q, rq_d;   // {partial remainder, dividend/quotient}
  logic [31:0]     dvs_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q;
  logic [32:0]     trial;

  // Partial remainder shifted left by one is rq_q[63:31]; it can need 33 bits.
  // A set trial[32] means the subtraction borrowed, so the bit is 0 and we restore.
  assign trial = rq_q[63:31] - {1'b0, dvs_q};

  always_comb begin
    rq_d = {rq_q[62:0], 1'b0};
    if (!trial[32]) begin
      rq_d = {trial[31:0], rq_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start) begin
      rq_q  <= {32'd0, dividend};
      dvs_q <= divisor;
      cnt_q <= CntW'(DIV_ITER - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      rq_q  <= rq_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end
    end
  end

  assign last = run_q && (cnt_q == '0);
  assign quot = rq_q[31:0];
  assign rem  = rq_q[63:32];

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Multiply/divide sequencer and owner of the architectural HI/LO registers (E stage).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   validE          E-stage instruction valid
//   hilo_opE        E instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   funct_to_aluE   funct field of the E instruction
//   src_aE, src_bE  forwarded rs / rt operands
//   flushE          exception flush of E; aborts any operation
//   pipe_stall      external stall holding E; defers the HI/LO commit
//   mdu_stallE      hold F/D/E while a multiply or divide is in flight
//   hilo_we         one-cycle pulse; HI/LO written at this edge
//   hi_q, lo_q      architectural HI and LO
//   busy            sequencer not idle
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MulLatDefault,
  parameter int unsigned DIV_ITER = DivIterDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validE,
  input  logic        hilo_opE,
  input  logic [5:0]  funct_to_aluE,
  input  logic [31:0] src_aE,
  input  logic [31:0] src_bE,
  input  logic        flushE,
  input  logic        pipe_stall,
  output logic        mdu_stallE,
  output logic        hilo_we,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        busy
);

  mdu_state_e  state_q, state_d;
  logic [2:0]  mul_cnt_q;
  logic [32:0] mul_a_q, mul_b_q;
  logic [63:0] pipe_q [MUL_LAT];
  logic [63:0] prod;
  logic        sign_a_q, sign_b_q;
  logic [63:0] res_q, done_res;
  logic        res_is_mul_q;

  logic is_mul, is_div, is_mthi, is_mtlo, is_signed, start;
  logic div_last;
  logic [31:0] div_quot, div_rem;

  assign is_mul    = (funct_to_aluE == FunctMult) || (funct_to_aluE == FunctMultu);
  assign is_div    = (funct_to_aluE == FunctDiv)  || (funct_to_aluE == FunctDivu);
  assign is_mthi   = (funct_to_aluE == FunctMthi);
  assign is_mtlo   = (funct_to_aluE == FunctMtlo);
  assign is_signed = (funct_to_aluE == FunctMult) || (funct_to_aluE == FunctDiv);
  assign start     = validE && hilo_opE && !flushE && (state_q == StIdle);

  div_radix2_core #(
    .DIV_ITER(DIV_ITER)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (start && is_div && (src_bE != '0)),
    .abort   (flushE),
    .dividend(abs32(src_aE, is_signed)),
    .divisor (abs32(src_bE, is_signed)),
    .last    (div_last),
    .quot    (div_quot),
    .rem     (div_rem)
  );

  // Low 64 bits of the 33x33 signed product equal the low 64 bits of the
  // same operands sign-extended to 64 bits and multiplied unsigned.
  assign prod = {{31{mul_a_q[32]}}, mul_a_q} * {{31{mul_b_q[32]}}, mul_b_q};

  // Operands stay latched until the next start, so the pipe output is stable in StDone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign done_res = res_is_mul_q ? pipe_q[MUL_LAT-1] : res_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && is_mul) begin
          state_d = StMulWait;
        end else if (start && is_div) begin
          state_d = (src_bE == '0) ? StDone : StDivRun;
        end
      end
      StMulWait: if (mul_cnt_q == '0) state_d = StDone;
      StDivRun:  if (div_last) state_d = StDivFix;
      StDivFix:  state_d = StDone;
      StDone:    if (!pipe_stall) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (flushE) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    mdu_stallE = (start && (is_mul || is_div)) || (state_q == StMulWait) ||
                 (state_q == StDivRun) || (state_q == StDivFix);
    hilo_we    = ((state_q == StDone) && !pipe_stall && !flushE) ||
                 (start && (is_mthi || is_mtlo) && !pipe_stall);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mul_cnt_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      res_q        <= '0;
      res_is_mul_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q <= state_d;
      if (start && is_mul) begin
        mul_a_q      <= {is_signed & src_aE[31], src_aE};
        mul_b_q      <= {is_signed & src_bE[31], src_bE};
        mul_cnt_q    <= 3'(MUL_LAT - 1);
        res_is_mul_q <= 1'b1;
      end else if (state_q == StMulWait) begin
        mul_cnt_q <= mul_cnt_q - 1'b1;
      end
      if (start && is_div) begin
        sign_a_q     <= is_signed & src_aE[31];
        sign_b_q     <= is_signed & src_bE[31];
        // Only survives to StDone when the divisor is zero.
        res_q        <= {src_aE, DivZeroLo};
        res_is_mul_q <= 1'b0;
      end else if (state_q == StDivFix) begin
        res_q <= {sign_a_q ? (~div_rem + 32'd1) : div_rem,
                  (sign_a_q ^ sign_b_q) ? (~div_quot + 32'd1) : div_quot};
      end
      if (hilo_we) begin
        if (state_q == StDone) begin
          hi_q <= done_res[63:32];
          lo_q <= done_res[31:0];
        end else if (is_mthi) begin
          hi_q <= src_aE;
        end else begin
          lo_q <= src_aE;
        end
      end
    end
  end

endmodule
